// File: rtl/cache_line_mover.sv
// Moves whole cache lines between the data_array line port and the memory word bus.
// Optional CACHE_LINE_MOVER_CWF_EN starts each transfer at req_word and wraps.
module cache_line_mover #(
    parameter int LINE_SIZE     = 16,
    parameter int NUM_SETS      = 4,
    parameter int ASSOCIATIVITY = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    localparam int IDX_W  = $clog2(NUM_SETS),
    localparam int WAY_W  = $clog2(ASSOCIATIVITY),
    localparam int LINE_W = LINE_SIZE * 8,
    localparam int WORDS  = LINE_W / DATA_WIDTH,
    localparam int PTR_W  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_evict,
    input  logic [IDX_W-1:0]      req_index,
    input  logic [WAY_W-1:0]      req_way,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [PTR_W-1:0]      req_word,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      arr_index,
    output logic [WAY_W-1:0]      arr_way,
    output logic                  arr_line_read_en,
    input  logic [LINE_W-1:0]     arr_line_read_data,
    output logic                  arr_line_write_en,
    output logic [LINE_W-1:0]     arr_line_write_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    // state    | meaning
    // IDLE     | waiting for a request, req_ready high
    // EV_RD    | one-cycle line read strobe to the array
    // EV_WAIT  | two-cycle array read latency, capture on exit
    // EV_SEND  | stream buffered line to memory as write beats
    // FL_REQ   | issue one memory read beat
    // FL_WAIT  | wait for the read word, store it in its slot
    // FL_WRITE | one-cycle line write to the array
    // DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, EV_RD, EV_WAIT, EV_SEND, FL_REQ, FL_WAIT, FL_WRITE, DONE
    } state_t;

    localparam int OFF_W   = $clog2(LINE_SIZE);
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [PTR_W-1:0]        word_ptr, ptr_inc, start_word;
    logic [PTR_W-1:0]        beats_left;
    logic                    wait_cnt;
    logic [LINE_W-1:0]       line_buf;

`ifdef CACHE_LINE_MOVER_CWF_EN
    assign start_word = req_word;
`else
    logic unused_req_word;
    assign start_word      = '0;
    assign unused_req_word = ^req_word;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[OFF_W-1:0];

    assign ptr_inc = (word_ptr == PTR_W'(WORDS - 1)) ? '0 : word_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arr_index  <= '0;
            arr_way    <= '0;
            base_addr  <= '0;
            word_ptr   <= '0;
            beats_left <= '0;
            wait_cnt   <= 1'b0;
            line_buf   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    arr_index  <= req_index;
                    arr_way    <= req_way;
                    base_addr  <= {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    word_ptr   <= start_word;
                    beats_left <= PTR_W'(WORDS - 1);
                end
                EV_RD: wait_cnt <= 1'b1;
                EV_WAIT: begin
                    if (wait_cnt != 1'b0) wait_cnt <= wait_cnt - 1'b1;
                    else                  line_buf <= arr_line_read_data;
                end
                EV_SEND: if (mem_ready) begin
                    word_ptr   <= ptr_inc;
                    beats_left <= beats_left - 1'b1;
                end
                FL_WAIT: if (mem_rvalid) begin
                    for (int k = 0; k < WORDS; k++)
                        if (word_ptr == PTR_W'(k))
                            line_buf[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                    word_ptr   <= ptr_inc;
                    beats_left <= beats_left - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt         = state;
        req_ready         = 1'b0;
        busy              = 1'b1;
        done              = 1'b0;
        arr_line_read_en  = 1'b0;
        arr_line_write_en = 1'b0;
        mem_valid         = 1'b0;
        mem_we            = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = req_evict ? EV_RD : FL_REQ;
            end
            EV_RD: begin
                arr_line_read_en = 1'b1;
                state_nxt        = EV_WAIT;
            end
            EV_WAIT: if (wait_cnt == 1'b0) state_nxt = EV_SEND;
            EV_SEND: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_ready && beats_left == '0) state_nxt = DONE;
            end
            FL_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) state_nxt = FL_WAIT;
            end
            // completion is decided by remaining beats, not by where the wrapping pointer sits
            FL_WAIT: if (mem_rvalid) state_nxt = (beats_left == '0) ? FL_WRITE : FL_REQ;
            FL_WRITE: begin
                arr_line_write_en = 1'b1;
                state_nxt         = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_wdata = '0;
        for (int k = 0; k < WORDS; k++)
            if (word_ptr == PTR_W'(k)) mem_wdata = line_buf[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign mem_addr            = base_addr + (ADDR_WIDTH'(word_ptr) << BYTE_SH);
    assign arr_line_write_data = line_buf;

endmodule

// File: tb/tb_cache_line_mover.sv
// Scoreboard bench for cache_line_mover: expected beats/lines queued at issue, popped when seen.
// Honours CACHE_LINE_MOVER_CWF_EN when computing the expected word order.
module tb_cache_line_mover;
    localparam int LINE_SIZE = 16, NUM_SETS = 4, ASSOC = 2, DW = 32, AW = 32;
    localparam int WORDS = 4, LW = 128;

    logic          clk, rst_n;
    logic          req_valid, req_ready, req_evict;
    logic [1:0]    req_index;
    logic          req_way;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_word;
    logic          busy, done;
    logic [1:0]    arr_index;
    logic          arr_way;
    logic          arr_line_read_en, arr_line_write_en;
    logic [LW-1:0] arr_line_read_data, arr_line_write_data;
    logic          mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    cache_line_mover #(.LINE_SIZE(LINE_SIZE), .NUM_SETS(NUM_SETS), .ASSOCIATIVITY(ASSOC),
                       .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_evict(req_evict), .req_index(req_index), .req_way(req_way), .req_addr(req_addr),
        .req_word(req_word), .busy(busy), .done(done), .arr_index(arr_index), .arr_way(arr_way),
        .arr_line_read_en(arr_line_read_en), .arr_line_read_data(arr_line_read_data),
        .arr_line_write_en(arr_line_write_en), .arr_line_write_data(arr_line_write_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_beats[$];
    logic [LW-1:0] exp_lines[$];
    int n_vec = 0, n_err = 0;
    int done_cnt = 0, line_wr_cnt = 0, rv_cnt = 0, wr_beats = 0, stall_left = 0;
    logic          rd_pend = 1'b0, stray_armed = 1'b0, stray_used = 1'b0;
    logic [AW-1:0] rd_addr = '0, held_addr = '0;
    logic [DW-1:0] held_data = '0;

    localparam logic [LW-1:0] LINE_A = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [LW-1:0] LINE_B = 128'hDDCCBBAA_44332211_87654321_0BADF00D;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_val(input int k);
        return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    endfunction

    // memory responder and output monitor, both evaluated mid-cycle
    initial begin
        beat_t b;
        logic [LW-1:0] l;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_rvalid = 1'b0; mem_ready = 1'b1; rd_pend = 1'b0;
                continue;
            end
            mem_rvalid = 1'b0; mem_rdata = '0;
            if (rd_pend) begin
                mem_rvalid = 1'b1; mem_rdata = word_val(int'(rd_addr[3:2]));
                rd_pend = 1'b0; rv_cnt++;
            end else if (stray_armed && mem_valid && !mem_we) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
                stray_armed = 1'b0; stray_used = 1'b1;
            end
            mem_ready = 1'b1;
            if (mem_valid && mem_we && wr_beats == 2 && stall_left > 0) begin
                mem_ready = 1'b0;
                if (stall_left == 3) begin
                    held_addr = mem_addr; held_data = mem_wdata;
                end else begin
                    check_val("hold_addr", mem_addr, held_addr);
                    check_val("hold_wdata", mem_wdata, held_data);
                end
                stall_left--;
            end
            if (mem_valid && mem_ready) begin
                if (exp_beats.size() == 0) check_val("unexpected_beat", mem_valid, 1'b0);
                else begin
                    b = exp_beats.pop_front();
                    check_val("beat_we", mem_we, b.we);
                    check_val("beat_addr", mem_addr, b.addr);
                    if (b.we) check_val("beat_wdata", mem_wdata, b.data);
                end
                if (mem_we) wr_beats++;
                else begin rd_pend = 1'b1; rd_addr = mem_addr; end
            end
            if (arr_line_write_en) begin
                line_wr_cnt++;
                if (exp_lines.size() == 0) check_val("unexpected_line_write", arr_line_write_en, 1'b0);
                else begin
                    l = exp_lines.pop_front();
                    check_val("line_data", arr_line_write_data, l);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic issue_req(input logic ev, input logic [1:0] idx, input logic way,
                             input logic [AW-1:0] addr, input logic [1:0] w);
        int start, k;
        logic [AW-1:0] base;
        beat_t b;
`ifdef CACHE_LINE_MOVER_CWF_EN
        start = int'(w);
`else
        start = 0;
`endif
        base = {addr[AW-1:4], 4'h0};
        for (int j = 0; j < WORDS; j++) begin
            k = (start + j) % WORDS;
            b.we = ev; b.addr = base + AW'(4*k);
            b.data = ev ? arr_line_read_data[32*k +: 32] : '0;
            exp_beats.push_back(b);
        end
        if (!ev) exp_lines.push_back(LINE_A);
        wr_beats = 0; rv_cnt = 0;
        @(negedge clk);
        check_val("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_evict = ev; req_index = idx; req_way = way;
        req_addr = addr; req_word = w;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("arr_index", arr_index, idx);
        check_val("arr_way", arr_way, way);
        check_val("busy_after_accept", busy, 1'b1);
        check_val("rd_strobe", arr_line_read_en, ev);
    endtask

    task automatic wait_done(input string tag);
        int d0;
        logic got;
        d0 = done_cnt; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (done) begin got = 1'b1; break; end
        end
        check_val({tag, "_done_seen"}, got, 1'b1);
        repeat (3) @(negedge clk);
        check_val({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_val({tag, "_beats_left"}, exp_beats.size(), 0);
        check_val({tag, "_lines_left"}, exp_lines.size(), 0);
        check_val({tag, "_idle"}, {busy, req_ready}, 2'b01);
    endtask

    initial begin
        int d0, lw0;
        rst_n = 1'b0; req_valid = 1'b0; req_evict = 1'b0; req_index = '0; req_way = '0;
        req_addr = '0; req_word = '0; arr_line_read_data = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy_done", {busy, done}, 2'b00);
        check_val("rst_strobes", {arr_line_read_en, arr_line_write_en, mem_valid, mem_we}, 4'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_mem_wdata", mem_wdata, 32'h0);
        check_val("rst_wr_data", arr_line_write_data, 128'h0);
        check_val("rst_arr_idx_way", {arr_index, arr_way}, 3'h0);
        check_val("rst_req_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_req_ready", req_ready, 1'b1);

        issue_req(1'b0, 2'd1, 1'b0, 32'h100, 2'd0);
        wait_done("fill");

        arr_line_read_data = LINE_A;
        issue_req(1'b1, 2'd2, 1'b1, 32'h2A4, 2'd0);
        wait_done("evict");

        arr_line_read_data = LINE_B;
        stall_left = 3;
        issue_req(1'b1, 2'd3, 1'b1, 32'h3C0, 2'd0);
        wait_done("backpressure");
        check_val("stall_consumed", stall_left, 0);

        stray_armed = 1'b1;
        issue_req(1'b0, 2'd0, 1'b1, 32'h040, 2'd0);
        repeat (2) begin
            @(negedge clk);
            req_valid = 1'b1; req_evict = 1'b1; req_index = 2'd3;
            check_val("busy_req_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done("busy_fill");
        check_val("stray_injected", stray_used, 1'b1);

        issue_req(1'b0, 2'd1, 1'b1, 32'h100, 2'd2);
        wait_done("cwf_fill");

        issue_req(1'b0, 2'd2, 1'b0, 32'h100, 2'd2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rv_cnt >= 2) break;
        end
        check_val("two_words_returned", rv_cnt >= 2, 1'b1);
        @(posedge clk); #2;
        d0 = done_cnt; lw0 = line_wr_cnt;
        rst_n = 1'b0;
        #1;
        check_val("abort_outputs", {busy, mem_valid, arr_line_write_en, done}, 4'h0);
        exp_beats.delete(); exp_lines.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);
        check_val("abort_no_line_write", line_wr_cnt - lw0, 0);
        check_val("abort_idle", req_ready, 1'b1);

        issue_req(1'b0, 2'd3, 1'b0, 32'h20C, 2'd1);
        wait_done("recover_fill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
